// File: rtl/ram8_arbiter.sv
// Round-robin arbiter sequencing two requesters onto one shared 8-word register bank.
// Latency: grant edge -> ACCESS (ram_load) -> RESP (ack); 3 cycles per transaction (2 with back-to-back grant).
// Backpressure: a requester holds req and its operands until it samples its ack; inputs are ignored outside IDLE.
//
// Ports:
//   clk, rstbar                        clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0, ack0        requester 0 request, operands and one-cycle completion pulse
//   req1/we1/addr1/wdata1, ack1        requester 1 request, operands and one-cycle completion pulse
//   rdata                              shared read data, valid while ack0 or ack1 is high
//   busy                               high whenever a transaction is in flight
//   ram_addr, ram_in, ram_load         bank address, write data and load strobe
//   ram_out                            bank combinational read data
//
// Optional feature macro: RAM8_ARB_BACK2BACK_EN
//   defined   -> the waiting requester is granted straight from RESP, skipping IDLE
//   undefined -> RESP always returns to IDLE
module ram8_arbiter #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              rstbar,
  input  logic              req0,
  input  logic              we0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [WIDTH-1:0]  wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]  wdata1,
  output logic              ack1,
  output logic [WIDTH-1:0]  rdata,
  output logic              busy,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_in,
  output logic              ram_load,
  input  logic [WIDTH-1:0]  ram_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_n;

  logic winner;       // requester owning the transaction in flight
  logic last_served;  // requester most recently served; loses the next tie
  logic we_q;         // registered write enable of the winner
  logic grant_vld;    // a grant happens at the coming edge
  logic grant_sel;    // which requester that grant goes to

  always_ff @(posedge clk or negedge rstbar) begin
    if (!rstbar) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    ram_load  = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_vld = 1'b1;
          // On a tie the requester that was not served last wins.
          if (req0 && req1) grant_sel = ~last_served;
          else              grant_sel = req1;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        ram_load = we_q;
        state_n  = RESP;
      end
      RESP: begin
        ack0    = ~winner;
        ack1    = winner;
        state_n = IDLE;
`ifdef RAM8_ARB_BACK2BACK_EN
        // Only the other requester may chain; the one just served goes back through IDLE.
        if (winner ? req0 : req1) begin
          grant_vld = 1'b1;
          grant_sel = ~winner;
          state_n   = ACCESS;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstbar) begin
    if (!rstbar) begin
      winner      <= 1'b0;
      last_served <= 1'b1;
      we_q        <= 1'b0;
      ram_addr    <= '0;
      ram_in      <= '0;
      rdata       <= '0;
    end else begin
      if (grant_vld) begin
        winner   <= grant_sel;
        we_q     <= grant_sel ? we1 : we0;
        ram_addr <= grant_sel ? addr1 : addr0;
        ram_in   <= grant_sel ? wdata1 : wdata0;
      end
      // rdata is captured on the same edge the bank loads, so a write
      // returns the word's previous contents.
      if (state == ACCESS) begin
        rdata       <= ram_out;
        last_served <= winner;
      end
    end
  end

endmodule

// File: doc/ram8_arbiter.md
Name: ram8_arbiter

Overview:
- Two-requester round-robin controller for one shared 8-word x 16-bit register bank (eight Register words, combinational read, load-on-clock write).
- Sequences each read or write as a fixed 3-state transaction and drives the bank's address, data-in and load lines.
- Returns read data and a one-cycle acknowledge to the winning requester.

Parameters:
WIDTH, 16, data word width
AWIDTH, 3, word address width (bank depth 2**AWIDTH)

Ports:
clk  input  1  rising-edge clock
rstbar  input  1  asynchronous active-low reset
req0  input  1  requester 0 transaction request (level)
we0  input  1  requester 0 write enable (1=write, 0=read)
addr0  input  AWIDTH  requester 0 word address
wdata0  input  WIDTH  requester 0 write data
ack0  output  1  requester 0 transaction complete, one-cycle pulse
req1, we1, addr1, wdata1, ack1  as above for requester 1
rdata  output  WIDTH  shared read data, valid while ack0 or ack1 high
busy  output  1  high while state != IDLE
ram_addr  output  AWIDTH  bank address
ram_in  output  WIDTH  bank write data
ram_load  output  1  bank load strobe
ram_out  input  WIDTH  bank combinational read data

Behaviour:
- rstbar low: immediate, clock-independent reset; state=IDLE; ack0=ack1=ram_load=busy=0; ram_addr=0; ram_in=0; rdata=0; last-served register=1, so requester 0 wins first.
- States: IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles.
- IDLE: sample req0/req1 at each rising edge. If none is set, stay in IDLE. If one is set, grant it. If both are set, grant the one not in last-served. At the granting edge, register the winner's addr/wdata/we into ram_addr/ram_in/an internal we, record the winner, and go to ACCESS.
- ACCESS: ram_load = registered we (combinational from state, high exactly this one cycle). At the closing edge the bank writes (if we); rdata captures ram_out; last-served is updated; state goes to RESP.
- rdata is read-before-write: on a write, rdata returns the word's previous contents.
- RESP: ack of the winner = 1, the other ack = 0; ram_load = 0. Next edge goes to IDLE.
- ram_addr and ram_in hold from grant until the next grant.
- rdata holds its value until the next ACCESS capture.
- Handshake: the requester keeps req/we/addr/wdata stable from assertion until it samples ack=1. For a single transaction it drops req at the edge that samples ack. If req stays high, the next IDLE sample starts a new transaction.
- Inputs are sampled only in IDLE; changes during ACCESS/RESP are ignored.
- Latency: req high at edge N (IDLE) -> ram_load in cycle N..N+1 -> ack high cycle N+1..N+2. Throughput is 1 transaction per 3 cycles.
- Both requests held continuously: grants strictly alternate 0,1,0,1...
- Reset during ACCESS: ram_load drops immediately, no write occurs, and no ack is issued. Bank contents are not reset by this block.
- Never asserts ack0 and ack1 together. ram_load is never high outside ACCESS.

Optional Feature:
RAM8_ARB_BACK2BACK_EN
- Defined: at the RESP closing edge, if the non-served requester's req is high, grant it directly (same registration as IDLE) and go to ACCESS, skipping IDLE. The just-served requester's req is ignored at that edge. Alternating throughput becomes 1 transaction per 2 cycles.
- Undefined: RESP always returns to IDLE, as above.

Test Plan:
- Reset: rstbar=0 mid-cycle -> all outputs 0 immediately, with no clock edge; after release, busy=0 with no requests.
- Write then read: req0 we0=1 addr0=3 wdata0=16'hBEEF -> one cycle later ram_load=1, ram_addr=3, ram_in=BEEF; next cycle ack0=1. Then req0 we0=0 addr0=3 -> ack0=1 with rdata=16'hBEEF; ram_load stays 0.
- Read-before-write: word 5 = 16'h1234; req1 we1=1 addr1=5 wdata1=16'h5678 -> ack1 with rdata=16'h1234; a subsequent read of 5 returns 16'h5678.
- Arbitration: req0 and req1 both held from reset -> ack order 0,1,0,1, ack pulses 3 cycles apart, never simultaneous.
- Reset mid-op: write to addr 2 of 16'hAAAA, rstbar low during ACCESS -> ram_load falls immediately, no ack; reading addr 2 afterwards returns its old value.
- Macro defined, both reqs held -> ack pulses 2 cycles apart, still alternating. Macro undefined -> 3 cycles apart.
